// File: rtl/addsub_seq_arb.sv
// -----------------------------------------------------------------------------
// addsub_seq_arb
//   Two-requester 32-bit add/subtract unit built around one shared 16-bit
//   ripple adder. An accepted operation takes two passes through the adder.
//   The low half is computed first, then the high half, which uses the low
//   carry. The result is then presented until the consumer takes it.
//   One operation completes every 4 cycles: IDLE -> LO -> HI -> RESP.
//
//   Parameters
//     RR_EN         1 = round-robin between requesters, 0 = requester 0 wins
//   Ports
//     clk, rst_n    clock, synchronous active-low reset
//     reqN_valid    requester N has an operation pending (N = 0, 1)
//     reqN_ready    requester N accepted this cycle (IDLE only)
//     reqN_a/_b     32-bit operands
//     reqN_sub      0 = a + b, 1 = a - b
//     rsp_valid     result available (RESP state)
//     rsp_ready     consumer takes the result
//     rsp_sum       a + b or a - b, modulo 2^32
//     rsp_cout      carry out of a + (b ^ {32{sub}}) + sub (sub: 1 = no borrow)
//     rsp_id        requester that issued the result
// -----------------------------------------------------------------------------

// 16-bit ripple-carry adder; purely combinational.
module ripple_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  always_comb begin
    logic carry;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

module addsub_seq_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_id
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

  state_e      state_q, state_d;
  logic        favour_q, favour_d;       // requester that wins when both are valid
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic [15:0] lo_sum_q, lo_sum_d;
  logic        lo_carry_q, lo_carry_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_cout_q, rsp_cout_d;
  logic        rsp_id_q, rsp_id_d;

  logic        grant;                    // requester offered ready this cycle
  logic        accept;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  // Arbitration and handshake. Readies are gated by rst_n so that nothing
  // is accepted in a cycle whose closing edge performs a reset.
  always_comb begin
    grant = favour_q;
    if (req0_valid && !req1_valid) grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
    req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  grant;
    accept     = req0_ready || req1_ready;
  end

  // Shared adder: the LO pass uses sub as carry-in (two's complement +1);
  // the HI pass chains the registered low carry.
  always_comb begin
    if (state_q == HI) begin
      add_a   = a_q[31:16];
      add_b   = b_q[31:16] ^ {16{sub_q}};
      add_cin = lo_carry_q;
    end else begin
      add_a   = a_q[15:0];
      add_b   = b_q[15:0] ^ {16{sub_q}};
      add_cin = sub_q;
    end
  end

  ripple_adder #(.W(16)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block infers a latch.
    state_d     = state_q;
    favour_d    = favour_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    lo_sum_d    = lo_sum_q;
    lo_carry_d  = lo_carry_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = LO;
          a_d      = grant ? req1_a   : req0_a;
          b_d      = grant ? req1_b   : req0_b;
          sub_d    = grant ? req1_sub : req0_sub;
          rsp_id_d = grant;
          if (RR_EN) favour_d = !grant;
        end
      end
      LO: begin
        lo_sum_d   = add_sum;
        lo_carry_d = add_cout;
        state_d    = HI;
      end
      HI: begin
        rsp_sum_d   = {add_sum, lo_sum_q};
        rsp_cout_d  = add_cout;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and everything visible on the outputs is reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      favour_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      favour_q    <= favour_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // NOTE: operand and low-half registers are not reset; each is written
  // before it is read within an operation, and reset aborts the operation.
  always_ff @(posedge clk) begin
    a_q        <= a_d;
    b_q        <= b_d;
    sub_q      <= sub_d;
    lo_sum_q   <= lo_sum_d;
    lo_carry_q <= lo_carry_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule
